// File: rtl/inv_share_ctrl.sv
// Round-robin front end that time-shares one GF(2^7) inverse unit among NREQ requesters.
// It sequences load/hold/wait for the unit and short-circuits a zero operand.
module inv_share_ctrl #(
   parameter int NREQ     = 4,
   parameter int ID_W     = 2,
   parameter int INV_WAIT = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [7*NREQ-1:0] req_data,
   output logic [NREQ-1:0]   req_ready,
   output logic              rsp_valid,
   output logic [6:0]        rsp_data,
   output logic [ID_W-1:0]   rsp_id,
   input  logic              rsp_ready,
   output logic [6:0]        inv_a,
   output logic              inv_load,
   input  logic [6:0]        inv_b
);

   localparam int CNT_W = $clog2(INV_WAIT) + 1;

   typedef enum logic [1:0] {IDLE, LOAD, RUN, RESP} state_t;

   state_t            state;
   logic [ID_W-1:0]   rr_ptr;
   logic [ID_W-1:0]   cur_id;
   logic [CNT_W-1:0]  cnt;

   logic              gnt_any;
   logic [ID_W-1:0]   gnt_idx;
   logic [ID_W-1:0]   gnt_nxt;
   logic [NREQ-1:0]   gnt_vec;
   logic [6:0]        gnt_op;

   // First valid requester at or after rr_ptr, wrapping.
   always_comb begin
      int j;
      j       = 0;
      gnt_any = 1'b0;
      gnt_idx = '0;
      gnt_vec = '0;
      gnt_op  = '0;
      for (int k = 0; k < NREQ; k++) begin
         j = (int'(rr_ptr) + k) % NREQ;
         if (!gnt_any && req_valid[j]) begin
            gnt_any    = 1'b1;
            gnt_idx    = ID_W'(j);
            gnt_vec[j] = 1'b1;
            gnt_op     = req_data[7*j +: 7];
         end
      end
   end

   assign gnt_nxt   = (gnt_idx == ID_W'(NREQ-1)) ? '0 : gnt_idx + ID_W'(1);
   assign req_ready = (state == IDLE) ? gnt_vec : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         rr_ptr    <= '0;
         cur_id    <= '0;
         cnt       <= '0;
         inv_load  <= 1'b0;
         inv_a     <= '0;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         rsp_id    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (gnt_any) begin
                  rr_ptr <= gnt_nxt;
                  cur_id <= gnt_idx;
                  if (gnt_op != 7'd0) begin
                     inv_a    <= gnt_op;
                     inv_load <= 1'b1;
                     state    <= LOAD;
                  end else begin
                     // Zero has no inverse and would never finish in the unit.
                     rsp_data  <= '0;
                     rsp_id    <= gnt_idx;
                     rsp_valid <= 1'b1;
                     state     <= RESP;
                  end
               end
            end
            LOAD: begin
               inv_load <= 1'b0;
               cnt      <= '0;
               state    <= RUN;
            end
            RUN: begin
               // inv_a stays put: the unit re-reads its operand every iteration.
               if (cnt == CNT_W'(INV_WAIT-1)) begin
                  rsp_data  <= inv_b;
                  rsp_id    <= cur_id;
                  rsp_valid <= 1'b1;
                  state     <= RESP;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_inv_share_ctrl.sv
// Scoreboard bench for inv_share_ctrl with a behavioural GF(2^7) inverse unit attached.
module tb_inv_share_ctrl;
   localparam int NREQ = 4, ID_W = 2, INV_WAIT = 32;

   logic              clk = 1'b0, rst = 1'b1;
   logic [NREQ-1:0]   req_valid = '0;
   logic [7*NREQ-1:0] req_data = '0;
   logic [NREQ-1:0]   req_ready;
   logic              rsp_valid;
   logic [6:0]        rsp_data;
   logic [ID_W-1:0]   rsp_id;
   logic              rsp_ready = 1'b1;
   logic [6:0]        inv_a;
   logic              inv_load;
   logic [6:0]        inv_b = '0;

   always #5 clk = ~clk;

   inv_share_ctrl #(.NREQ(NREQ), .ID_W(ID_W), .INV_WAIT(INV_WAIT)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
      .rsp_id(rsp_id), .rsp_ready(rsp_ready), .inv_a(inv_a),
      .inv_load(inv_load), .inv_b(inv_b));

   int checks = 0, errors = 0, cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [6:0] gfmul(input logic [6:0] a, input logic [6:0] b);
      logic [6:0] p, aa;
      p = '0; aa = a;
      for (int i = 0; i < 7; i++) begin
         if (b[i]) p = p ^ aa;
         aa = aa[6] ? ((aa << 1) ^ 7'h03) : (aa << 1);
      end
      return p;
   endfunction

   function automatic logic [6:0] ginv(input logic [6:0] a);
      for (int b = 1; b < 128; b++)
         if (gfmul(a, 7'(b)) == 7'h01) return 7'(b);
      return 7'h00;
   endfunction

   // Inverse unit: junk on load, true inverse of the held operand 31 edges later.
   int ucnt = 0;
   always @(posedge clk) begin
      if (inv_load) begin
         ucnt  <= 1;
         inv_b <= 7'h5A;
      end else if (ucnt != 0) begin
         if (ucnt == 31) begin
            inv_b <= ginv(inv_a);
            ucnt  <= 0;
         end else ucnt <= ucnt + 1;
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   int               exp_gnt[$];
   logic [ID_W+6:0]  exp_rsp[$];
   logic [6:0]       lq[NREQ][$];

   task automatic push(input int lane, input logic [6:0] op, input logic [6:0] res, input bit want_rsp);
      lq[lane].push_back(op);
      exp_gnt.push_back(lane);
      if (want_rsp) exp_rsp.push_back({ID_W'(lane), res});
   endtask

   // Requester driver and grant checker.
   int  xfer_cyc = -100, drv_lane;
   bit  xfer_zero = 0, inflight = 0;
   initial forever begin
      drv_lane = -1;
      @(negedge clk);
      if (!rst && (req_valid & req_ready) != '0) begin
         for (int l = 0; l < NREQ; l++)
            if (req_valid[l] && req_ready[l]) drv_lane = l;
         chk("grant_onehot", int'(req_ready), 1 << drv_lane);
         if (exp_gnt.size() == 0) chk("unexpected_grant", drv_lane, -1);
         else chk("grant_id", drv_lane, exp_gnt.pop_front());
         xfer_cyc  = cyc;
         xfer_zero = (req_data[7*drv_lane +: 7] == 7'd0);
         inflight  = 1'b1;
      end
      @(posedge clk); #1;
      if (drv_lane >= 0 && lq[drv_lane].size() > 0) void'(lq[drv_lane].pop_front());
      for (int l = 0; l < NREQ; l++) begin
         req_valid[l]         = (lq[l].size() != 0);
         req_data[7*l +: 7]   = (lq[l].size() != 0) ? lq[l][0] : 7'h3C;
      end
   end

   // Response monitor.
   bit              prev_v = 0, prev_hs = 0;
   logic [6:0]      prev_d = '0;
   logic [ID_W-1:0] prev_id = '0;
   logic [ID_W+6:0] e;
   always @(negedge clk) begin
      if (rst) begin
         prev_v = 0; prev_hs = 0;
      end else begin
         if (inflight && cyc > xfer_cyc) chk("busy_no_grant", int'(req_ready), 0);
         if (prev_hs && req_valid != '0) chk("grant_after_hs", int'(req_ready != '0), 1);
         if (inv_load) begin
            chk("load_delay", cyc - xfer_cyc, 1);
            chk("load_nonzero_op", int'(xfer_zero), 0);
         end
         if (rsp_valid && !prev_v)
            chk("rsp_latency", cyc - xfer_cyc, xfer_zero ? 1 : INV_WAIT + 2);
         if (prev_v && !prev_hs) begin
            chk("hold_valid", int'(rsp_valid), 1);
            if (rsp_valid) begin
               chk("hold_data", rsp_data, prev_d);
               chk("hold_id", rsp_id, prev_id);
            end
         end
         if (rsp_valid && rsp_ready) begin
            if (exp_rsp.size() == 0) chk("unexpected_rsp", int'(rsp_id), -1);
            else begin
               e = exp_rsp.pop_front();
               chk("rsp_id", rsp_id, e[ID_W+6:7]);
               chk("rsp_data", rsp_data, e[6:0]);
            end
            inflight = 1'b0;
         end
         prev_v = rsp_valid; prev_hs = rsp_valid && rsp_ready;
         prev_d = rsp_data;  prev_id = rsp_id;
      end
   end

   task automatic check_reset();
      @(negedge clk);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_inv_load", inv_load, 0);
      chk("rst_inv_a", inv_a, 0);
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_rsp_id", rsp_id, 0);
      chk("rst_req_ready", int'(req_ready), 0);
   endtask

   task automatic pulse_reset();
      @(posedge clk); #1 rst = 1'b1; inflight = 1'b0;
      @(posedge clk); #1 rst = 1'b0;
      check_reset();
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while ((exp_gnt.size() != 0 || exp_rsp.size() != 0) && n < budget) begin
         @(posedge clk); n++;
      end
      chk("drain_timeout", exp_gnt.size() + exp_rsp.size(), 0);
      repeat (3) @(posedge clk);
      #1;
   endtask

   initial begin
      int n;
      logic [6:0] op;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check_reset();

      // 1: single nonzero op
      push(1, 7'h02, 7'h41, 1);
      drain(200);
      pulse_reset();

      // 2: two contenders from rr_ptr=0
      push(0, 7'h03, 7'h7E, 1);
      push(2, 7'h01, 7'h01, 1);
      drain(300);

      // 3: rr_ptr=3 so lane 3 (zero bypass) wins over lane 1
      push(3, 7'h00, 7'h00, 1);
      push(1, 7'h04, 7'h61, 1);
      drain(300);

      // 4: backpressure with all lanes valid, rr_ptr=2
      rsp_ready = 1'b0;
      push(2, 7'h04, 7'h61, 1);
      push(3, 7'h01, 7'h01, 1);
      push(0, 7'h02, 7'h41, 1);
      push(1, 7'h03, 7'h7E, 1);
      n = 0;
      while (!rsp_valid && n < 100) begin @(negedge clk); n++; end
      chk("bp_rsp_seen", int'(rsp_valid), 1);
      repeat (20) @(posedge clk);
      #1 rsp_ready = 1'b1;
      drain(400);

      // 5: reset in the middle of RUN (rr_ptr=2 before)
      push(2, 7'h02, 7'h00, 0);
      n = 0;
      while (!inv_load && n < 100) begin @(negedge clk); n++; end
      chk("abort_load_seen", int'(inv_load), 1);
      repeat (10) @(posedge clk);
      #1 rst = 1'b1; inflight = 1'b0;
      @(posedge clk); #1 rst = 1'b0;
      check_reset();
      repeat (50) @(posedge clk);
      push(1, 7'h02, 7'h41, 1);
      push(3, 7'h03, 7'h7E, 1);
      drain(300);

      // 6: fairness sweep, all lanes continuously valid
      for (int r = 0; r < 10; r++)
         for (int l = 0; l < NREQ; l++) begin
            op = 7'($urandom_range(1, 127));
            push(l, op, ginv(op), 1);
         end
      drain(3000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      errors++;
      $display("FAIL watchdog: simulation did not finish in time");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/inv_share_ctrl.md
Name: inv_share_ctrl

Overview:
- Round-robin scheduler that shares one GF(2^7) inverse unit among NREQ requesters.
- The inverse unit computes modulo P(x)=x^7+x+1, has a 7-bit operand input, a 7-bit result output and a load strobe.
- The block accepts one operand per transaction, sequences the unit (load pulse, hold operand, fixed wait) and returns the result tagged with the requester id.
- It provides the done/latency control the unit lacks and bypasses a=0, which never terminates in the unit.

Parameters:
- NREQ, 4, number of requesters (2..8).
- ID_W, 2, width of the requester id; must be at least ceil(log2(NREQ)).
- INV_WAIT, 32, cycles waited after the load cycle before sampling the unit result. Must be >= 32, the worst-case iteration bound for 7-bit operands plus the output-register cycle.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  NREQ  per-requester operand valid.
- req_data  in  7*NREQ  operands; requester i occupies bits [7i+6:7i].
- req_ready  out  NREQ  one-hot grant; a transfer occurs when req_valid[i] & req_ready[i].
- rsp_valid  out  1  result valid.
- rsp_data  out  7  inverse result.
- rsp_id  out  ID_W  index of the requester that owns rsp_data.
- rsp_ready  in  1  consumer accepts the result.
- inv_a  out  7  operand to the inverse unit.
- inv_load  out  1  load strobe to the inverse unit.
- inv_b  in  7  result from the inverse unit.

Behaviour:
- Reset (rst=1 at a clk edge), all registered:
  - state=IDLE, rr_ptr=0, inv_load=0, inv_a=0.
  - rsp_valid=0, rsp_data=0, rsp_id=0, wait counter=0.
  - Any in-flight operation is discarded with no response. Reset in any state, including RUN and RESP, behaves identically.
- States: IDLE, LOAD, RUN, RESP.
- IDLE:
  - req_ready is combinational and one-hot: the first i with req_valid[i]=1, searching from rr_ptr upward and wrapping modulo NREQ.
  - req_ready is all zeros when no request is valid and in every non-IDLE state.
  - On transfer, latch op=req_data[i] and id=i, and set rr_ptr=(i+1) mod NREQ.
  - If op!=0: inv_a<=op, go to LOAD.
  - If op==0: rsp_data<=0, rsp_id<=i, rsp_valid<=1, go to RESP. The unit is not touched.
- LOAD:
  - inv_load=1 for exactly this one cycle; inv_a already holds op.
  - Go to RUN with counter=0.
- RUN:
  - inv_load=0; inv_a is held stable, because the unit reads its operand every iteration.
  - The counter increments each cycle.
  - When the counter reaches INV_WAIT-1: rsp_data<=inv_b, rsp_id<=id, rsp_valid<=1, go to RESP.
- RESP:
  - rsp_valid, rsp_data and rsp_id are held stable until rsp_valid & rsp_ready.
  - On that handshake, in the same edge: rsp_valid<=0, go to IDLE.
  - No new grant is issued in the handshake cycle; the next grant is possible one cycle later.
  - inv_a stays held until the next load; its value outside RUN is don't-care to consumers.
- Latency, from the transfer cycle to rsp_valid rising:
  - nonzero op: 2+INV_WAIT cycles (34 at default).
  - op==0: 1 cycle.
- Throughput: one operation in flight at a time.
- Fairness: no requester waits more than NREQ-1 transactions while holding req_valid.
- Requester contract: req_data[i] only needs to be valid in its transfer cycle. A requester may drop req_valid before it is granted, with no side effects.
- Out-of-range ids: none; bits of req_* at indices >= NREQ do not exist.

Test Plan:
1. Reset, then requester 1 sends 0x02 -> req_ready=0b0010 in that cycle; inv_load pulses 1 cycle later; rsp_valid rises 34 cycles after transfer with rsp_data=0x41, rsp_id=1.
2. Requesters 0 and 2 valid simultaneously with 0x03 and 0x01, rr_ptr=0, rsp_ready=1 -> grant 0 first (rsp 0x7E, id 0), then grant 2 (rsp 0x01, id 2); rr_ptr ends at 3.
3. Zero bypass: requester 3 sends 0x00 -> inv_load never asserts; rsp_valid=1 one cycle later with rsp_data=0x00, rsp_id=3.
4. Backpressure: rsp_ready=0 for 20 cycles during RESP while all req_valid=1 -> rsp_* stable, req_ready=0 throughout; after the handshake, the next grant goes to rr_ptr's requester one cycle later.
5. Reset mid-RUN: assert rst at cycle 10 of RUN -> next cycle state=IDLE, rsp_valid=0, inv_load=0, no response for the aborted op; a new 0x02 request completes with 0x41.
6. Fairness sweep: all four requesters continuously valid with random nonzero operands for 40 transactions -> grants rotate 0,1,2,3,... and every rsp_data times its operand equals 1 modulo x^7+x+1.
